replica_pair_sched: RTL and testbench
=====================================

# replica_pair_sched

Parametrised replica-exchange pair scheduler for the parallel-tempering TSP array. It generalises the fixed two-node pairing to NODE_NUM replicas with alternating even/odd pairing per round. It snapshots every node's total distance and walks the adjacent pairs of the current parity serially. For each pair it issues one Metropolis request to the shared exp/compare unit over a valid/ready handshake, then returns a per-node exchange mask and an accept count to the ordering/distance exchange logic.

## Interface
- NODE_NUM, 32, number of replica nodes; must be ≥2.
- DIST_W, 24, total-distance width, unsigned.
- ALT_PARITY, 1, 1: parity toggles every round; 0: always even pairing.
- CNT_W, $clog2(NODE_NUM/2+1), accept-counter width (derived).

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  round request pulse; honoured only in IDLE.
- dist_i  in  NODE_NUM*DIST_W  packed total distances; node n at [n*DIST_W +: DIST_W].
- busy  out  1  high in REQ/WAIT/DONE.
- done  out  1  one-cycle pulse at round end.
- parity_o  out  1  parity of the current/last round.
- req_valid  out  1  Metropolis request valid.
- req_ready  in  1  Metropolis unit ready.
- req_id  out  $clog2(NODE_NUM)  lower node index i of the pair (i, i+1).
- req_delta  out  DIST_W+1  signed dist[i] − dist[i+1].
- rsp_valid  in  1  test result valid.
- rsp_accept  in  1  1 = swap the pair.
- exchange_o  out  NODE_NUM  bit n set: node n swaps with its partner.
- acc_cnt  out  CNT_W  number of accepted pairs this round.

## Operation
- Reset values: busy=0, done=0, parity_o=0, req_valid=0, req_id=0, req_delta=0, exchange_o=0, acc_cnt=0, state IDLE.
- IDLE: start=1 → snapshot dist_i into internal registers, clear exchange_o and acc_cnt, set i=parity.
  - If the pair count floor((NODE_NUM−parity)/2) is 0, go to DONE.
  - Otherwise go to REQ.
- REQ: req_valid=1, req_id=i, req_delta=zero-extended dist[i] − zero-extended dist[i+1] in DIST_W+1 bits.
  - These outputs are stable until req_valid&req_ready; then go to WAIT.
- WAIT: req_valid=0. On rsp_valid=1:
  - if rsp_accept, set exchange_o[i] and exchange_o[i+1] and increment acc_cnt;
  - then i+=2; if i+1 ≤ NODE_NUM−1 go to REQ, else go to DONE.
- DONE: done=1 for exactly one cycle. Parity toggles if ALT_PARITY. Return to IDLE.
- exchange_o and acc_cnt hold their values until the next accepted start.
- Pairing: parity 0 uses (0,1),(2,3),…; parity 1 uses (1,2),(3,4),…. Node 0 (parity 1) and the last node (odd leftover) are never marked.
- parity_o shows the parity of the round in progress, or of the next round while IDLE.
- Boundary rules:
  - start while busy is ignored, with no effect on snapshot or counters.
  - rsp_valid outside WAIT is ignored.
  - dist_i changes after the snapshot do not affect the round.
  - reset asserted in any state returns all outputs to reset values next edge; the round is abandoned and parity returns to 0.
  - acc_cnt never exceeds NODE_NUM/2; no overflow is possible by construction of CNT_W.

## Timing
- start sampled at edge of cycle 0 → REQ visible in cycle 1.
- Per pair, minimum 2 cycles: REQ handshake, then WAIT with rsp_valid in the following cycle.
- K pairs, req_ready=1 and rsp after one cycle: done high in cycle 2K+1. Zero pairs: done in cycle 1.
- exchange_o bits update on the edge that samples rsp_valid and are valid together with done.
- No combinational path from inputs to outputs; all outputs are registered.

## Test plan
- NODE_NUM=4, parity 0, dist={10,5,7,9}, ready=1, accept=1 for both pairs:
  - req_delta +5 then −2;
  - exchange_o=4'b1111, acc_cnt=2, done in cycle 5, parity_o→1.
- Following round, parity 1, same dist, accept=0:
  - single request id=1, delta=−2;
  - exchange_o=0, acc_cnt=0, done in cycle 3, parity_o→0.
- Backpressure: hold req_ready=0 for 3 cycles. req_valid, req_id and req_delta stay constant; the handshake occurs on the first cycle with ready=1; start pulses during busy are ignored.
- NODE_NUM=2, parity 1 round: no req_valid at all, done in cycle 1, exchange_o=0.
- Width extremes, DIST_W=24, dist[0]=0, dist[1]=2^24−1: req_delta=−(2^24−1), i.e. 25'h1000001.
- Reset asserted during WAIT: next cycle all outputs are zero and parity_o=0. The next start runs a clean parity-0 round; a stale rsp_valid arriving in IDLE has no effect.

Source files
------------

// File: rtl/replica_pair_sched.sv
// replica_pair_sched: walks the even/odd adjacent replica pairs of one
// parallel-tempering round, issuing one Metropolis request per pair.
module replica_pair_sched #(
    parameter int NODE_NUM   = 32,
    parameter int DIST_W     = 24,
    parameter bit ALT_PARITY = 1'b1,
    parameter int CNT_W      = $clog2(NODE_NUM / 2 + 1)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [NODE_NUM*DIST_W-1:0]   dist_i,
    output logic                         busy,
    output logic                         done,
    output logic                         parity_o,
    output logic                         req_valid,
    input  logic                         req_ready,
    output logic [$clog2(NODE_NUM)-1:0]  req_id,
    output logic [DIST_W:0]              req_delta,
    input  logic                         rsp_valid,
    input  logic                         rsp_accept,
    output logic [NODE_NUM-1:0]          exchange_o,
    output logic [CNT_W-1:0]             acc_cnt
);
    localparam int IW = $clog2(NODE_NUM);
    // one spare bit so i+2 past the last pair never wraps
    localparam int XW = IW + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE
    } state_t;

    state_t                      state_q, state_d;
    logic [NODE_NUM*DIST_W-1:0]  snap_q, snap_d;
    logic [XW-1:0]               idx_q, idx_d;
    logic                        par_q, par_d;
    logic [NODE_NUM-1:0]         exch_q, exch_d;
    logic [CNT_W-1:0]            acc_q, acc_d;
    logic [DIST_W:0]             delta_q, delta_d;

    function automatic logic [DIST_W-1:0] pick(
        input logic [NODE_NUM*DIST_W-1:0] v,
        input int                         n
    );
        pick = '0;
        if (n >= 0 && n < NODE_NUM) begin
            pick = v[n*DIST_W +: DIST_W];
        end
    endfunction

    always_comb begin
        state_d = state_q;
        snap_d  = snap_q;
        idx_d   = idx_q;
        par_d   = par_q;
        exch_d  = exch_q;
        acc_d   = acc_q;
        delta_d = delta_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    snap_d = dist_i;
                    exch_d = '0;
                    acc_d  = '0;
                    idx_d  = XW'(par_q);
                    if (NODE_NUM - int'(par_q) < 2) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (req_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (rsp_valid) begin
                    if (rsp_accept) begin
                        for (int n = 0; n < NODE_NUM; n++) begin
                            if (n == int'(idx_q) || n == int'(idx_q) + 1) begin
                                exch_d[n] = 1'b1;
                            end
                        end
                        acc_d = acc_q + CNT_W'(1);
                    end
                    idx_d = idx_q + XW'(2);
                    if (int'(idx_q) + 3 <= NODE_NUM - 1) begin
                        state_d = S_REQ;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                if (ALT_PARITY) begin
                    par_d = ~par_q;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // latch the pair's delta once on REQ entry so it holds under backpressure
        if (state_d == S_REQ && state_q != S_REQ) begin
            delta_d = {1'b0, pick(snap_d, int'(idx_d))}
                    - {1'b0, pick(snap_d, int'(idx_d) + 1)};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            snap_q  <= '0;
            idx_q   <= '0;
            par_q   <= 1'b0;
            exch_q  <= '0;
            acc_q   <= '0;
            delta_q <= '0;
        end else begin
            state_q <= state_d;
            snap_q  <= snap_d;
            idx_q   <= idx_d;
            par_q   <= par_d;
            exch_q  <= exch_d;
            acc_q   <= acc_d;
            delta_q <= delta_d;
        end
    end

    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);
    assign req_valid  = (state_q == S_REQ);
    assign parity_o   = par_q;
    assign req_id     = idx_q[IW-1:0];
    assign req_delta  = delta_q;
    assign exchange_o = exch_q;
    assign acc_cnt    = acc_q;
endmodule

// File: tb/tb_replica_pair_sched.sv
// tb_replica_pair_sched: directed rounds on a 4-node and a 2-node
// scheduler with hand-computed deltas, masks, counts and latencies.
module tb_replica_pair_sched;
    logic clk = 1'b0;
    logic rst, st, rdy, rsp_v, rsp_a, sel;
    logic [95:0] dist4;
    logic [47:0] dist2;

    logic       busy4, done4, par4, rv4;
    logic [1:0] id4;
    logic [24:0] dl4;
    logic [3:0] ex4;
    logic [1:0] acc4;

    logic       busy2, done2, par2, rv2;
    logic [0:0] id2;
    logic [24:0] dl2;
    logic [1:0] ex2;
    logic [0:0] acc2;

    logic        o_busy, o_done, o_par, o_rv;
    logic [1:0]  o_id, o_acc;
    logic [24:0] o_dl;
    logic [3:0]  o_ex;

    int n_chk = 0;
    int n_pass = 0;
    logic [1:0]  q_id[$];
    logic [24:0] q_dl[$];
    bit stable;
    int d;

    always #5 clk = ~clk;

    replica_pair_sched #(.NODE_NUM(4), .DIST_W(24)) u4 (
        .clk(clk), .reset(rst), .start(st & ~sel), .dist_i(dist4),
        .busy(busy4), .done(done4), .parity_o(par4),
        .req_valid(rv4), .req_ready(rdy), .req_id(id4),
        .req_delta(dl4), .rsp_valid(rsp_v), .rsp_accept(rsp_a),
        .exchange_o(ex4), .acc_cnt(acc4)
    );

    replica_pair_sched #(.NODE_NUM(2), .DIST_W(24)) u2 (
        .clk(clk), .reset(rst), .start(st & sel), .dist_i(dist2),
        .busy(busy2), .done(done2), .parity_o(par2),
        .req_valid(rv2), .req_ready(rdy), .req_id(id2),
        .req_delta(dl2), .rsp_valid(rsp_v), .rsp_accept(rsp_a),
        .exchange_o(ex2), .acc_cnt(acc2)
    );

    always_comb begin
        o_busy = sel ? busy2 : busy4;
        o_done = sel ? done2 : done4;
        o_par  = sel ? par2 : par4;
        o_rv   = sel ? rv2 : rv4;
        o_id   = sel ? {1'b0, id2} : id4;
        o_dl   = sel ? dl2 : dl4;
        o_ex   = sel ? {2'b00, ex2} : ex4;
        o_acc  = sel ? {1'b0, acc2} : acc4;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [39:0] got,
                         input logic [39:0] exp);
        n_chk++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic run(input bit s, input logic [1:0] acc_pat,
                       input int hold, input bit poke,
                       input logic [95:0] junk, output int dcyc);
        int ka, held;
        bit pend, inreq;
        logic [1:0]  rid;
        logic [24:0] rdl;
        sel = s;
        q_id.delete();
        q_dl.delete();
        stable = 1'b1;
        ka = 0; held = 0; pend = 0; inreq = 0; dcyc = -1;
        rid = '0; rdl = '0;
        rdy = 1'b1; rsp_v = 1'b0; rsp_a = 1'b0;
        st = 1'b1;
        tick();
        st = 1'b0;
        if (s) dist2 = junk[47:0];
        else dist4 = junk;
        for (int c = 1; c < 40; c++) begin
            st = 1'b0;
            if (o_done) begin
                dcyc = c;
                break;
            end
            rsp_v = pend;
            rsp_a = pend & acc_pat[ka];
            if (pend) ka++;
            pend = 0;
            if (o_rv) begin
                if (!inreq) begin
                    rid = o_id;
                    rdl = o_dl;
                    inreq = 1;
                end else if (o_id !== rid || o_dl !== rdl) begin
                    stable = 1'b0;
                end
                if (held < hold) begin
                    rdy = 1'b0;
                    held++;
                    if (poke) st = 1'b1;
                end else begin
                    rdy = 1'b1;
                    q_id.push_back(o_id);
                    q_dl.push_back(o_dl);
                    pend = 1;
                    inreq = 0;
                end
            end
            tick();
        end
        rsp_v = 1'b0; rsp_a = 1'b0; st = 1'b0; rdy = 1'b1;
        if (dcyc < 0) check("round_timeout", 40'd0, 40'd1);
    endtask

    function automatic logic [39:0] pack();
        return {o_busy, o_done, o_par, o_rv, o_id, o_dl, o_ex, o_acc};
    endfunction

    initial begin
        rst = 1'b1; st = 1'b0; rdy = 1'b1; rsp_v = 1'b0; rsp_a = 1'b0;
        sel = 1'b0;
        dist4 = {24'd9, 24'd7, 24'd5, 24'd10};
        dist2 = {24'hFFFFFF, 24'd0};
        tick();
        tick();
        sel = 1'b0;
        check("rst4_outs", pack(), 40'd0);
        sel = 1'b1;
        check("rst2_outs", pack(), 40'd0);
        rst = 1'b0;
        tick();

        // parity 0, both accepted
        dist4 = {24'd9, 24'd7, 24'd5, 24'd10};
        run(1'b0, 2'b11, 0, 1'b0, {4{24'hABCDEF}}, d);
        check("A_nreq", q_id.size(), 2);
        check("A_id0", q_id[0], 0);
        check("A_dl0", q_dl[0], 25'd5);
        check("A_id1", q_id[1], 2);
        check("A_dl1", q_dl[1], 25'h1FFFFFE);
        check("A_exch", o_ex, 4'b1111);
        check("A_acc", o_acc, 2);
        check("A_done_cyc", d, 5);
        tick();
        check("A_done_pulse", o_done, 0);
        check("A_parity", o_par, 1);

        // parity 1, rejected
        dist4 = {24'd9, 24'd7, 24'd5, 24'd10};
        run(1'b0, 2'b00, 0, 1'b0, {4{24'h123456}}, d);
        check("B_nreq", q_id.size(), 1);
        check("B_id", q_id[0], 1);
        check("B_dl", q_dl[0], 25'h1FFFFFE);
        check("B_exch", o_ex, 0);
        check("B_acc", o_acc, 0);
        check("B_done_cyc", d, 3);
        tick();
        check("B_parity", o_par, 0);

        // backpressure with start pokes while busy
        dist4 = {24'd9, 24'd7, 24'd5, 24'd10};
        run(1'b0, 2'b01, 3, 1'b1, {4{24'h000001}}, d);
        check("C_stable", stable, 1);
        check("C_nreq", q_id.size(), 2);
        check("C_dl0", q_dl[0], 25'd5);
        check("C_dl1", q_dl[1], 25'h1FFFFFE);
        check("C_exch", o_ex, 4'b0011);
        check("C_acc", o_acc, 1);
        check("C_done_cyc", d, 8);
        tick();
        check("C_parity", o_par, 1);
        tick();
        check("C_idle_after", o_busy, 0);

        // reset in WAIT, stale response in IDLE, clean round
        sel = 1'b0;
        rdy = 1'b1;
        st = 1'b1;
        tick();
        st = 1'b0;
        tick();
        check("D_in_wait", {o_busy, o_rv}, 2'b10);
        rst = 1'b1;
        tick();
        check("D_rst_outs", pack(), 40'd0);
        rst = 1'b0;
        rsp_v = 1'b1;
        rsp_a = 1'b1;
        tick();
        rsp_v = 1'b0;
        rsp_a = 1'b0;
        check("D_stale", {o_busy, o_ex, o_acc}, 0);
        dist4 = {24'd9, 24'd7, 24'd5, 24'd10};
        run(1'b0, 2'b11, 0, 1'b0, {4{24'h555555}}, d);
        check("D_id0", q_id[0], 0);
        check("D_exch", o_ex, 4'b1111);
        check("D_done_cyc", d, 5);

        // two nodes: width extreme, then the zero-pair parity-1 round
        dist2 = {24'hFFFFFF, 24'd0};
        run(1'b1, 2'b01, 0, 1'b0, {4{24'h777777}}, d);
        check("E_nreq", q_id.size(), 1);
        check("E_dl", q_dl[0], 25'h1000001);
        check("E_exch", o_ex, 4'b0011);
        check("E_acc", o_acc, 1);
        check("E_done_cyc", d, 3);
        tick();
        check("E_parity", o_par, 1);
        run(1'b1, 2'b11, 0, 1'b0, {4{24'h777777}}, d);
        check("F_nreq", q_id.size(), 0);
        check("F_done_cyc", d, 1);
        check("F_exch", o_ex, 0);
        check("F_acc", o_acc, 0);
        tick();
        check("F_parity", o_par, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
